// File: rtl/data_pattern_gen.sv
// Burst pattern generator: emits LEN_I words of a constant, increment, LFSR or
// walking-one sequence on a valid/ready stream, with busy/done status.
module data_pattern_gen #(
  parameter int unsigned             P_WIDTH     = 8,
  parameter int unsigned             P_LEN_W     = 8,
  parameter logic [P_WIDTH-1:0]      P_LFSR_TAPS = 8'hB8,
  parameter int unsigned             P_DELAY     = 1
) (
  input  logic               CLK_I,
  input  logic               RST_X,
  input  logic               START_I,
  input  logic [1:0]         MODE_I,
  input  logic [P_LEN_W-1:0] LEN_I,
  input  logic [P_WIDTH-1:0] SEED_I,
  input  logic               ABORT_I,
  output logic [P_WIDTH-1:0] DATA_O,
  output logic               VALID_O,
  input  logic               READY_I,
  output logic               BUSY_O,
  output logic               DONE_O
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] LP_MODE_CONST = 2'd0;
  localparam logic [1:0] LP_MODE_INCR  = 2'd1;
  localparam logic [1:0] LP_MODE_LFSR  = 2'd2;
  localparam logic [1:0] LP_MODE_WALK  = 2'd3;
  localparam logic [P_WIDTH-1:0] LP_ONE = {{(P_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_LEN_W-1:0] LP_LEN_ONE = {{(P_LEN_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [P_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           mode_q, mode_d;
  logic [P_LEN_W-1:0]   cnt_q, cnt_d;
  logic                 xfer_s;

  // Update delays are not modelled; the parameter stays for drop-in compatibility.
  logic unused_delay_s;
  assign unused_delay_s = ^P_DELAY;

  function automatic logic [P_WIDTH-1:0] first_word(input logic [1:0] mode,
                                                    input logic [P_WIDTH-1:0] seed);
    case (mode)
      LP_MODE_LFSR: first_word = (seed == '0) ? LP_ONE : seed;
      LP_MODE_WALK: first_word = LP_ONE;
      default:      first_word = seed;
    endcase
  endfunction

  function automatic logic [P_WIDTH-1:0] next_word(input logic [1:0] mode,
                                                   input logic [P_WIDTH-1:0] cur);
    case (mode)
      LP_MODE_CONST: next_word = cur;
      LP_MODE_INCR:  next_word = cur + LP_ONE;
      LP_MODE_LFSR:  next_word = cur[0] ? ((cur >> 1) ^ P_LFSR_TAPS) : (cur >> 1);
      LP_MODE_WALK:  next_word = {cur[P_WIDTH-2:0], cur[P_WIDTH-1]};
      default:       next_word = cur;
    endcase
  endfunction

  assign xfer_s = valid_q & READY_I;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START_I) begin
          busy_d = 1'b1;
          if (LEN_I != '0) begin
            mode_d  = MODE_I;
            cnt_d   = LEN_I;
            data_d  = first_word(MODE_I, SEED_I);
            valid_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          cnt_d = cnt_q - LP_LEN_ONE;
          if (cnt_q == LP_LEN_ONE) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            data_d = next_word(mode_q, data_q);
          end
        end else begin
          state_d = ST_RUN;
        end
        // Abort overrides a coincident final transfer, so no done pulse follows.
        if (ABORT_I) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DATA_O  = data_q;
  assign VALID_O = valid_q;
  assign BUSY_O  = busy_q;
  assign DONE_O  = done_q;

endmodule

// File: tb/tb_data_pattern_gen.sv
// Directed self-checking bench for data_pattern_gen (8-bit default configuration).
module tb_data_pattern_gen;

  logic       CLK_I = 1'b0;
  logic       RST_X;
  logic       START_I;
  logic [1:0] MODE_I;
  logic [7:0] LEN_I;
  logic [7:0] SEED_I;
  logic       ABORT_I;
  logic [7:0] DATA_O;
  logic       VALID_O;
  logic       READY_I;
  logic       BUSY_O;
  logic       DONE_O;

  int errors = 0;
  int checks = 0;
  logic [7:0] words[$];

  data_pattern_gen dut (
    .CLK_I(CLK_I), .RST_X(RST_X), .START_I(START_I), .MODE_I(MODE_I),
    .LEN_I(LEN_I), .SEED_I(SEED_I), .ABORT_I(ABORT_I), .DATA_O(DATA_O),
    .VALID_O(VALID_O), .READY_I(READY_I), .BUSY_O(BUSY_O), .DONE_O(DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Start a burst with READY held high; collect accepted words until DONE_O.
  task automatic run_burst(input logic [1:0] mode, input logic [7:0] seed,
                           input logic [7:0] len, output logic done_seen);
    words.delete();
    done_seen = 1'b0;
    MODE_I = mode; SEED_I = seed; LEN_I = len; READY_I = 1'b1; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (DONE_O) begin
        done_seen = 1'b1;
        break;
      end
      if (VALID_O && READY_I) words.push_back(DATA_O);
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    RST_X = 1'b0; START_I = 1'b0; MODE_I = 2'd0; LEN_I = 8'd0; SEED_I = 8'd0;
    ABORT_I = 1'b0; READY_I = 1'b0;
    tick(); tick();
    checks++;
    if ({DATA_O, VALID_O, BUSY_O, DONE_O} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b/%b/%b want 00/0/0/0", DATA_O, VALID_O, BUSY_O, DONE_O);
    end
    RST_X = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    MODE_I = 2'd0; SEED_I = 8'h37; LEN_I = 8'd5; READY_I = 1'b0; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    checks++;
    if (VALID_O !== 1'b1 || DATA_O !== 8'h37) begin
      errors++;
      $display("FAIL reset_mid_setup: got valid=%b data=%h want 1/37", VALID_O, DATA_O);
    end
    #2 RST_X = 1'b0;
    #1;
    checks++;
    if ({DATA_O, VALID_O, BUSY_O, DONE_O} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h/%b/%b/%b want 00/0/0/0", DATA_O, VALID_O, BUSY_O, DONE_O);
    end
    tick();
    RST_X = 1'b1;
    READY_I = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (VALID_O !== 1'b0 || BUSY_O !== 1'b0 || DONE_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got valid=%b busy=%b done=%b want 0/0/0", VALID_O, BUSY_O, DONE_O);
    end
  endtask

  task automatic test_incr_backpressure();
    logic [7:0] exp_w[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic       rdy[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] held;
    int k = 0;
    MODE_I = 2'd1; SEED_I = 8'hFE; LEN_I = 8'd4; READY_I = 1'b0; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    for (int i = 0; i < 5; i++) begin
      READY_I = rdy[i];
      #1;
      held = DATA_O;
      if (VALID_O && READY_I && k < 4) begin
        checks++;
        if (DATA_O !== exp_w[k]) begin
          errors++;
          $display("FAIL incr_word%0d: got %h want %h", k, DATA_O, exp_w[k]);
        end
        k++;
      end
      tick();
      if (!rdy[i]) begin
        checks++;
        if (DATA_O !== held || VALID_O !== 1'b1) begin
          errors++;
          $display("FAIL incr_stall: got data=%h valid=%b want %h/1", DATA_O, VALID_O, held);
        end
      end
    end
    checks++;
    if (k != 4 || DONE_O !== 1'b1 || VALID_O !== 1'b0 || DATA_O !== 8'h01) begin
      errors++;
      $display("FAIL incr_done: got beats=%0d done=%b valid=%b data=%h want 4/1/0/01", k, DONE_O, VALID_O, DATA_O);
    end
    tick();
    checks++;
    if (DONE_O !== 1'b0 || BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL incr_fin_exit: got done=%b busy=%b want 0/0", DONE_O, BUSY_O);
    end
  endtask

  task automatic test_lfsr();
    logic done_seen;
    logic seen[256];
    int distinct = 0;
    logic bad = 1'b0;
    run_burst(2'd2, 8'h00, 8'd3, done_seen);
    checks++;
    if (!done_seen || words.size() != 3 || words[0] !== 8'h01 || words[1] !== 8'hB8 || words[2] !== 8'h5C) begin
      errors++;
      $display("FAIL lfsr_seed0: got n=%0d %p want 01 b8 5c", words.size(), words);
    end
    run_burst(2'd2, 8'h01, 8'd255, done_seen);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    foreach (words[i]) begin
      if (words[i] == 8'h00) bad = 1'b1;
      else if (!seen[words[i]]) begin
        seen[words[i]] = 1'b1;
        distinct++;
      end
    end
    checks++;
    if (!done_seen || bad || distinct != 255 || words.size() != 255) begin
      errors++;
      $display("FAIL lfsr_full: got distinct=%0d n=%0d zero=%b done=%b want 255/255/0/1", distinct, words.size(), bad, done_seen);
    end
  endtask

  task automatic test_walk_const();
    logic done_seen;
    logic [7:0] exp_w[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    run_burst(2'd3, 8'hAA, 8'd9, done_seen);
    checks++;
    if (!done_seen || words.size() != 9) begin
      errors++;
      $display("FAIL walk_len: got n=%0d done=%b want 9/1", words.size(), done_seen);
    end
    for (int i = 0; i < 9 && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL walk_word%0d: got %h want %h", i, words[i], exp_w[i]);
      end
    end
    run_burst(2'd0, 8'h11, 8'd2, done_seen);
    checks++;
    if (!done_seen || words.size() != 2 || words[0] !== 8'h11 || words[1] !== 8'h11) begin
      errors++;
      $display("FAIL const: got n=%0d %p want 11 11", words.size(), words);
    end
  endtask

  task automatic test_zero_len_and_ignored_start();
    int n = 0;
    MODE_I = 2'd1; SEED_I = 8'h50; LEN_I = 8'd0; READY_I = 1'b1; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    checks++;
    if (DONE_O !== 1'b1 || BUSY_O !== 1'b1 || VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got done=%b busy=%b valid=%b want 1/1/0", DONE_O, BUSY_O, VALID_O);
    end
    tick();
    checks++;
    if (DONE_O !== 1'b0 || BUSY_O !== 1'b0 || VALID_O !== 1'b0 || DATA_O !== 8'h11) begin
      errors++;
      $display("FAIL zero_len_exit: got done=%b busy=%b valid=%b data=%h want 0/0/0/11", DONE_O, BUSY_O, VALID_O, DATA_O);
    end
    words.delete();
    MODE_I = 2'd1; SEED_I = 8'h10; LEN_I = 8'd3; START_I = 1'b1;
    tick();
    MODE_I = 2'd3; SEED_I = 8'h99; LEN_I = 8'd7;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (VALID_O && READY_I) words.push_back(DATA_O);
      if (DONE_O) n++;
      tick();
      START_I = (cyc < 3);
    end
    START_I = 1'b0;
    checks++;
    if (words.size() != 3 || words[0] !== 8'h10 || words[1] !== 8'h11 || words[2] !== 8'h12 || n != 1) begin
      errors++;
      $display("FAIL ignored_start: got n=%0d dones=%0d %p want 3 beats 10 11 12, 1 done", words.size(), n, words);
    end
    tick(); tick();
  endtask

  task automatic test_abort();
    int beats = 0;
    int dones = 0;
    MODE_I = 2'd1; SEED_I = 8'h00; LEN_I = 8'd10; READY_I = 1'b1; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
      if (VALID_O && READY_I) begin
        beats++;
        ABORT_I = (beats == 3);
      end
      tick();
    end
    ABORT_I = 1'b0;
    checks++;
    if (beats != 3 || VALID_O !== 1'b0 || BUSY_O !== 1'b0 || DONE_O !== 1'b0) begin
      errors++;
      $display("FAIL abort: got beats=%0d valid=%b busy=%b done=%b want 3/0/0/0", beats, VALID_O, BUSY_O, DONE_O);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (DONE_O) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d valid=%b want 0/0", dones, VALID_O);
    end
  endtask

  task automatic test_back_to_back();
    MODE_I = 2'd0; SEED_I = 8'h5A; LEN_I = 8'd1; READY_I = 1'b1; START_I = 1'b1;
    tick();
    START_I = 1'b0;
    tick();
    checks++;
    if (DONE_O !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got done=%b want 1", DONE_O);
    end
    SEED_I = 8'hA5; START_I = 1'b1;
    tick();
    checks++;
    if (BUSY_O !== 1'b0 || VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b valid=%b want 0/0", BUSY_O, VALID_O);
    end
    tick();
    START_I = 1'b0;
    checks++;
    if (VALID_O !== 1'b1 || DATA_O !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b data=%h want 1/a5", VALID_O, DATA_O);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_incr_backpressure();
    test_lfsr();
    test_walk_const();
    test_zero_len_and_ignored_start();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
